int_mul_sequencer: RTL and testbench
====================================

Name: int_mul_sequencer

Overview:
Multi-cycle unsigned integer multiplier controller for the Int_ALU. It sequences a single shared 4x4 nibble multiplier across all nibble pairs of two WIDTH-bit operands, producing a full 2*WIDTH-bit product. The block accumulates one partial product per cycle and uses valid/ready handshakes on both the operand and result sides. It sits between the ALU issue logic and the result writeback mux.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
NIB (localparam), WIDTH/4, number of nibbles per operand.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operands A/B presented
in_ready  out  1  block can accept operands (IDLE only)
A  in  WIDTH  multiplicand
B  in  WIDTH  multiplier
out_valid  out  1  PRODUCT valid, held until accepted
out_ready  in  1  consumer accepts PRODUCT
PRODUCT  out  2*WIDTH  product/accumulator register
busy  out  1  high in MUL and DONE
SIGNED  in  1  present only with SIGNED_MUL_EN; treat A/B as two's complement

Behaviour:
- Reset (rst=1 at edge): state=IDLE, PRODUCT=0, out_valid=0, busy=0, nibble counters i=j=0, operand regs=0. rst has priority over every other event, including mid-MUL and DONE; in-flight results are discarded and no out_valid is produced.
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready (cycle T): latch A, B, clear PRODUCT to 0, i=j=0.
  - If A==0 or B==0, go to DONE (early-out, out_valid at T+1, PRODUCT=0).
  - Otherwise go to MUL.
- MUL: each cycle PRODUCT += ({pp8} << 4*(i+j)), where pp8 = A_nib[i]*B_nib[j] is the 8-bit nibble product. i is the inner loop, j the outer loop.
  - After i=j=NIB-1, go to DONE.
  - MUL lasts exactly NIB*NIB cycles (16 for WIDTH=16), so out_valid rises at T+NIB*NIB+1.
  - Accumulation is modulo 2^(2*WIDTH); the final sum never overflows.
- DONE: out_valid=1; PRODUCT stable. When out_ready=1, go to IDLE next cycle (out_valid=0, in_ready=1). There is no same-cycle accept of new operands in DONE.
- in_valid while not in IDLE is ignored (in_ready=0); A/B changes outside the accept cycle have no effect.
- busy=1 iff state is MUL or DONE.
- PRODUCT is meaningful only while out_valid=1.

Optional Feature:
Macro INT_MUL_SIGNED_MUL_EN.
- Defined: SIGNED port exists. At accept, if SIGNED=1, latch |A| and |B| (unsigned WIDTH-bit magnitudes; the most negative value maps to 2^(WIDTH-1)) and record neg = A[MSB]^B[MSB]. On entering DONE, PRODUCT is two's-complement negated when neg=1. Early-out zero still yields 0 with no negation. Latency is unchanged; the negation is folded into the last MUL cycle.
- Undefined: no SIGNED port; unsigned only.

Decomposition:
- Package int_alu_pkg: state enum (IDLE/MUL/DONE), NIBBLE_W=4 constant, function for nibble extract/shift amount.
- Sub-module nibble_mul_4x4: combinational, 4-bit A/B in, 8-bit product out, instantiated once.
- Counters, accumulator and FSM live in int_mul_sequencer.

Test Plan:
1. Reset check: hold rst 2 cycles → PRODUCT=0, out_valid=0, busy=0; in_ready=1 the cycle after rst falls.
2. Full-scale operands: WIDTH=16, A=0xFFFF, B=0xFFFF accepted at T → out_valid at T+17 with PRODUCT=0xFFFE0001. A=0x1234, B=0x5678 → 0x06260060.
3. Early-out: A=0x1234, B=0x0000 → out_valid at T+1, PRODUCT=0x00000000; in_ready=0 until accepted.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid and PRODUCT stay constant, in_ready=0. in_valid pulses with other operands are ignored. out_ready=1 → IDLE next cycle.
5. Reset mid-operation: assert rst at the 8th MUL cycle → next cycle IDLE, PRODUCT=0, out_valid never asserts. The next op, A=3, B=5, returns 0x0000000F at T+17.
6. INT_MUL_SIGNED_MUL_EN:
   - SIGNED=1, A=0xFFFE, B=0x0003 → 0xFFFFFFFA.
   - SIGNED=1, A=0x8000, B=0x8000 → 0x40000000.
   - SIGNED=0, A=0xFFFE, B=0x0003 → 0x0002FFFA.

Source files
------------

// File: rtl/int_alu_pkg.sv
// Shared definitions for the Int_ALU multiplier sequencer: FSM state
// encoding, nibble width, and helpers for nibble extraction and the
// partial-product alignment shift.
package int_alu_pkg;

  // Width of one operand slice handled by the shared multiplier
  localparam int NIBBLE_W = 4;

  // Largest operand width the nibble helper can slice
  localparam int MAX_OPERAND_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Return nibble number idx of a (zero-extended) operand
  function automatic logic [NIBBLE_W-1:0] nib_extract(
    input logic [MAX_OPERAND_W-1:0] value,
    input int                       idx
  );
    return value[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

  // Bit position where the product of nibbles i and j lands
  function automatic int nib_shift(input int i, input int j);
    return NIBBLE_W * (i + j);
  endfunction

endpackage

// File: rtl/int_mul_sequencer_if.sv
// Operand/result handshake bundle for int_mul_sequencer.
// The SIGNED request bit only exists when INT_MUL_SIGNED_MUL_EN is defined.
interface int_mul_sequencer_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] PRODUCT;
  logic               busy;
`ifdef INT_MUL_SIGNED_MUL_EN
  logic               SIGNED;

  // Issue side (ALU issue logic / writeback consumer)
  modport master (
    output in_valid, A, B, SIGNED, out_ready,
    input  in_ready, out_valid, PRODUCT, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, A, B, SIGNED, out_ready,
    output in_ready, out_valid, PRODUCT, busy
  );
`else
  // Issue side (ALU issue logic / writeback consumer)
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, PRODUCT, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, PRODUCT, busy
  );
`endif
endinterface

// File: rtl/nibble_mul_4x4.sv
// Combinational 4x4 unsigned multiplier producing a full 8-bit product.
// The sequencer time-shares a single instance over every nibble pair.
module nibble_mul_4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // Full-width product so no carry bits are lost
  always_comb begin
    p_o = 8'(a_i) * 8'(b_i);
  end

endmodule

// File: rtl/int_mul_sequencer.sv
// Multi-cycle unsigned multiplier: one nibble partial product per cycle,
// accumulated into a 2*WIDTH-bit product register.
// Optional feature macro: INT_MUL_SIGNED_MUL_EN (two's-complement operands
// selected per request through the SIGNED bit).
module int_mul_sequencer
  import int_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  int_mul_sequencer_if.slave bus
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int PW  = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIB - 1);

  mul_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    j_q;
  logic [PW-1:0]    prod_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_q;

  logic [NIBBLE_W-1:0] a_nib_d;
  logic [NIBBLE_W-1:0] b_nib_d;
  logic [7:0]          pp8_d;
  logic [PW-1:0]       sum_d;
  logic [PW-1:0]       final_d;
  logic                last_d;
  logic                zero_op_d;
  logic [WIDTH-1:0]    a_mag_d;
  logic [WIDTH-1:0]    b_mag_d;

`ifdef INT_MUL_SIGNED_MUL_EN
  logic neg_q;
  logic neg_d;
`endif

  // Select the current nibble pair and align its product into the accumulator
  always_comb begin
    a_nib_d = nib_extract(MAX_OPERAND_W'(a_q), int'(i_q));
    b_nib_d = nib_extract(MAX_OPERAND_W'(b_q), int'(j_q));
    sum_d   = prod_q + (PW'(pp8_d) << nib_shift(int'(i_q), int'(j_q)));
    last_d  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  end

  nibble_mul_4x4 u_nib_mul (
    .a_i (a_nib_d),
    .b_i (b_nib_d),
    .p_o (pp8_d)
  );

`ifdef INT_MUL_SIGNED_MUL_EN
  // Signed requests are multiplied as magnitudes; the sign is applied at the
  // end. Negating the most negative value wraps to 2^(WIDTH-1), which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    a_mag_d   = (bus.SIGNED && bus.A[WIDTH-1]) ? (-bus.A) : bus.A;
    b_mag_d   = (bus.SIGNED && bus.B[WIDTH-1]) ? (-bus.B) : bus.B;
    neg_d     = bus.SIGNED && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    zero_op_d = (bus.A == '0) || (bus.B == '0);
    final_d   = neg_q ? (-sum_d) : sum_d;
  end
`else
  // Unsigned only: operands are latched as presented
  always_comb begin
    a_mag_d   = bus.A;
    b_mag_d   = bus.B;
    zero_op_d = (bus.A == '0) || (bus.B == '0);
    final_d   = sum_d;
  end
`endif

  // Control FSM, nibble counters, operand and accumulator registers.
  // Handshake outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef INT_MUL_SIGNED_MUL_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= a_mag_d;
            b_q        <= b_mag_d;
            i_q        <= '0;
            j_q        <= '0;
            prod_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef INT_MUL_SIGNED_MUL_EN
            neg_q      <= neg_d;
`endif
            // A zero operand skips the nibble loop; the cleared product is final
            if (zero_op_d) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_MUL;
            end
          end
        end

        ST_MUL: begin
          // i sweeps the multiplicand nibbles, j advances once per sweep
          if (i_q == LAST_IDX) begin
            i_q <= '0;
            if (j_q == LAST_IDX) begin
              j_q         <= '0;
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              j_q <= j_q + CW'(1);
            end
          end else begin
            i_q <= i_q + CW'(1);
          end
          // Sign correction rides on the final accumulate so latency is unchanged
          prod_q <= last_d ? final_d : sum_d;
        end

        ST_DONE: begin
          // Hold the result until the consumer takes it; no new accept here
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Drive the handshake bundle from registered state
  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = out_valid_q;
    bus.busy      = busy_q;
    bus.PRODUCT   = prod_q;
  end

endmodule

// File: tb/tb_int_mul_sequencer.sv
// Self-checking bench for int_mul_sequencer (WIDTH=16): directed cases,
// backpressure, reset mid-operation and randomized operands checked
// against an arithmetic reference model.
module tb_int_mul_sequencer;

  localparam int WIDTH   = 16;
  localparam int MUL_LAT = 17;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  int_mul_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  int_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Reference: the product as plain integer arithmetic
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input bit s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] ua;
    logic [31:0] ub;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return 32'(sa * sb);
    end
    ua = {16'h0, a};
    ub = {16'h0, b};
    return ua * ub;
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
    return (a == 16'h0 || b == 16'h0) ? 1 : MUL_LAT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then scramble A/B
  task automatic issue_op(input logic [15:0] a, input logic [15:0] b, input bit s);
    ifc.in_valid = 1'b1;
    ifc.A = a;
    ifc.B = b;
`ifdef INT_MUL_SIGNED_MUL_EN
    ifc.SIGNED = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
    tick();
    ifc.in_valid = 1'b0;
    ifc.A = 16'($urandom);
    ifc.B = 16'($urandom);
  endtask

  // Cycle index (accept cycle = 0) at which out_valid is first seen
  task automatic wait_done(output int lat, output bit timed_out);
    lat = 1;
    while (ifc.out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    timed_out = (ifc.out_valid !== 1'b1);
  endtask

  task automatic accept_result();
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (ifc.PRODUCT !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=%h", ifc.PRODUCT, 32'h0); end
    checks++;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    rst = 1'b0;
    tick();
    checks++;
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
    $display("reset: product=%h out_valid=%b busy=%b in_ready=%b", ifc.PRODUCT, ifc.out_valid, ifc.busy, ifc.in_ready);
  endtask

  task automatic test_full_scale();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [31:0] kv [3];
    int lat;
    bit to;
    av = '{16'hFFFF, 16'h1234, 16'h0003};
    bv = '{16'hFFFF, 16'h5678, 16'h0005};
    kv = '{32'hFFFE0001, 32'h06260060, 32'h0000000F};
    for (int k = 0; k < 3; k++) begin
      issue_op(av[k], bv[k], 1'b0);
      checks++;
      if (ifc.busy !== 1'b1 || ifc.in_ready !== 1'b0) begin
        errors++; $display("FAIL full_busy busy=%b in_ready=%b exp busy=1 in_ready=0", ifc.busy, ifc.in_ready);
      end
      wait_done(lat, to);
      checks++;
      if (to || lat != MUL_LAT) begin errors++; $display("FAIL full_latency got=%0d exp=%0d timeout=%b", lat, MUL_LAT, to); end
      checks++;
      if (ifc.PRODUCT !== kv[k] || ifc.PRODUCT !== ref_mul(av[k], bv[k], 1'b0)) begin
        errors++; $display("FAIL full_product a=%h b=%h got=%h exp=%h", av[k], bv[k], ifc.PRODUCT, kv[k]);
      end
      $display("full: a=%h b=%h product=%h lat=%0d", av[k], bv[k], ifc.PRODUCT, lat);
      accept_result();
    end
  endtask

  task automatic test_early_out();
    int lat;
    bit to;
    issue_op(16'h1234, 16'h0000, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || lat != 1) begin errors++; $display("FAIL early_latency got=%0d exp=1 timeout=%b", lat, to); end
    checks++;
    if (ifc.PRODUCT !== 32'h0) begin errors++; $display("FAIL early_product got=%h exp=%h", ifc.PRODUCT, 32'h0); end
    tick();
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL early_hold in_ready=%b out_valid=%b busy=%b exp 0/1/1", ifc.in_ready, ifc.out_valid, ifc.busy);
    end
    accept_result();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL early_release in_ready=%b out_valid=%b busy=%b exp 1/0/0", ifc.in_ready, ifc.out_valid, ifc.busy);
    end
    $display("early_out: a=1234 b=0000 product=%h lat=%0d", ifc.PRODUCT, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    logic [31:0] exp_p;
    exp_p = ref_mul(16'h1234, 16'h5678, 1'b0);
    issue_op(16'h1234, 16'h5678, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || lat != MUL_LAT) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d timeout=%b", lat, MUL_LAT, to); end
    for (int c = 0; c < 5; c++) begin
      ifc.in_valid = 1'b1;
      ifc.A = 16'($urandom_range(1, 65535));
      ifc.B = 16'($urandom_range(1, 65535));
      tick();
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.PRODUCT !== exp_p || ifc.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d out_valid=%b product=%h in_ready=%b exp 1/%h/0", c, ifc.out_valid, ifc.PRODUCT, ifc.in_ready, exp_p);
      end
    end
    ifc.in_valid = 1'b0;
    accept_result();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b exp 1/0/0", ifc.in_ready, ifc.out_valid, ifc.busy);
    end
    // The ignored pulses must not have disturbed the next operation
    issue_op(16'h0007, 16'h0009, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || ifc.PRODUCT !== ref_mul(16'h0007, 16'h0009, 1'b0)) begin
      errors++; $display("FAIL bp_next got=%h exp=%h timeout=%b", ifc.PRODUCT, ref_mul(16'h0007, 16'h0009, 1'b0), to);
    end
    $display("backpressure: held product=%h next product=%h", exp_p, ifc.PRODUCT);
    accept_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    bit seen_valid;
    issue_op(16'hBEEF, 16'h1234, 1'b0);
    repeat (7) tick();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_state busy=%b out_valid=%b exp 1/0", ifc.busy, ifc.out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.PRODUCT !== 32'h0 || ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset busy=%b product=%h out_valid=%b in_ready=%b exp 0/0/0/1", ifc.busy, ifc.PRODUCT, ifc.out_valid, ifc.in_ready);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifc.out_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin errors++; $display("FAIL mid_no_valid got=1 exp=0"); end
    issue_op(16'h0003, 16'h0005, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || lat != MUL_LAT || ifc.PRODUCT !== 32'h0000000F) begin
      errors++; $display("FAIL mid_next lat=%0d product=%h exp lat=%0d product=0000000f", lat, ifc.PRODUCT, MUL_LAT);
    end
    $display("reset_mid: next product=%h lat=%0d", ifc.PRODUCT, lat);
    accept_result();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    int lat;
    bit to;
    for (int n = 0; n < 24; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 5) == 0) a = 16'h0;
      if ($urandom_range(0, 5) == 0) b = 16'h0;
      issue_op(a, b, 1'b0);
      wait_done(lat, to);
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (to || lat != ref_lat(a, b) || ifc.PRODUCT !== ref_mul(a, b, 1'b0)) begin
        errors++; $display("FAIL random a=%h b=%h lat=%0d product=%h exp lat=%0d product=%h", a, b, lat, ifc.PRODUCT, ref_lat(a, b), ref_mul(a, b, 1'b0));
      end
      $display("random: a=%h b=%h product=%h lat=%0d", a, b, ifc.PRODUCT, lat);
      accept_result();
    end
  endtask

`ifdef INT_MUL_SIGNED_MUL_EN
  task automatic test_signed();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    bit          sv [3];
    logic [31:0] kv [3];
    logic [15:0] a;
    logic [15:0] b;
    bit s;
    int lat;
    bit to;
    av = '{16'hFFFE, 16'h8000, 16'hFFFE};
    bv = '{16'h0003, 16'h8000, 16'h0003};
    sv = '{1'b1, 1'b1, 1'b0};
    kv = '{32'hFFFFFFFA, 32'h40000000, 32'h0002FFFA};
    for (int k = 0; k < 3; k++) begin
      issue_op(av[k], bv[k], sv[k]);
      wait_done(lat, to);
      checks++;
      if (to || lat != MUL_LAT || ifc.PRODUCT !== kv[k]) begin
        errors++; $display("FAIL signed_directed a=%h b=%h s=%b lat=%0d product=%h exp %h", av[k], bv[k], sv[k], lat, ifc.PRODUCT, kv[k]);
      end
      $display("signed: a=%h b=%h s=%b product=%h lat=%0d", av[k], bv[k], sv[k], ifc.PRODUCT, lat);
      accept_result();
    end
    for (int n = 0; n < 16; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      if ($urandom_range(0, 7) == 0) b = 16'h0;
      issue_op(a, b, s);
      wait_done(lat, to);
      checks++;
      if (to || lat != ref_lat(a, b) || ifc.PRODUCT !== ref_mul(a, b, s)) begin
        errors++; $display("FAIL signed_random a=%h b=%h s=%b lat=%0d product=%h exp lat=%0d product=%h", a, b, s, lat, ifc.PRODUCT, ref_lat(a, b), ref_mul(a, b, s));
      end
      $display("signed_random: a=%h b=%h s=%b product=%h", a, b, s, ifc.PRODUCT);
      accept_result();
    end
    ifc.SIGNED = 1'b0;
  endtask
`endif

  initial begin
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.A         = '0;
    ifc.B         = '0;
    ifc.out_ready = 1'b0;
`ifdef INT_MUL_SIGNED_MUL_EN
    ifc.SIGNED    = 1'b0;
`endif
    #1;
    test_reset();
    test_full_scale();
    test_early_out();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef INT_MUL_SIGNED_MUL_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
